// File: rtl/pearson_stream.sv
// pearson_stream: byte-serial Pearson hash engine with HASH_BYTES independent 8-bit lanes.
// Lane j starts from byte offset j of the first key byte, then follows h = T[h ^ k].
// Optional build macro PEARSON_SEED_EN adds an 8-bit seed port that is XORed into the
// first lookup; without it the seed is taken as zero.
module pearson_stream #(
    parameter int unsigned HASH_BYTES = 1,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
`ifdef PEARSON_SEED_EN
    input  logic [7:0]              seed,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*HASH_BYTES-1:0] out_hash,
    output logic [LEN_W-1:0]        out_len
);

    // Standard 256-entry Pearson permutation shared by every lane.
    localparam logic [7:0] PearsonTable [256] = '{
        8'd251, 8'd175, 8'd119, 8'd215, 8'd81,  8'd14,  8'd79,  8'd191,
        8'd103, 8'd49,  8'd181, 8'd143, 8'd186, 8'd157, 8'd0,   8'd232,
        8'd31,  8'd32,  8'd55,  8'd60,  8'd152, 8'd58,  8'd17,  8'd237,
        8'd174, 8'd70,  8'd160, 8'd144, 8'd220, 8'd90,  8'd57,  8'd223,
        8'd59,  8'd3,   8'd18,  8'd140, 8'd111, 8'd166, 8'd203, 8'd196,
        8'd134, 8'd243, 8'd124, 8'd95,  8'd222, 8'd179, 8'd197, 8'd65,
        8'd180, 8'd48,  8'd36,  8'd15,  8'd107, 8'd46,  8'd233, 8'd130,
        8'd165, 8'd30,  8'd123, 8'd161, 8'd209, 8'd23,  8'd97,  8'd16,
        8'd40,  8'd91,  8'd219, 8'd61,  8'd100, 8'd10,  8'd210, 8'd109,
        8'd250, 8'd127, 8'd22,  8'd138, 8'd29,  8'd108, 8'd244, 8'd67,
        8'd207, 8'd9,   8'd178, 8'd204, 8'd74,  8'd98,  8'd126, 8'd249,
        8'd167, 8'd116, 8'd34,  8'd77,  8'd193, 8'd200, 8'd121, 8'd5,
        8'd20,  8'd113, 8'd71,  8'd35,  8'd128, 8'd13,  8'd182, 8'd94,
        8'd25,  8'd226, 8'd227, 8'd199, 8'd75,  8'd27,  8'd41,  8'd245,
        8'd230, 8'd224, 8'd43,  8'd225, 8'd177, 8'd26,  8'd155, 8'd150,
        8'd212, 8'd142, 8'd218, 8'd115, 8'd241, 8'd73,  8'd88,  8'd105,
        8'd39,  8'd114, 8'd62,  8'd255, 8'd192, 8'd201, 8'd145, 8'd214,
        8'd168, 8'd158, 8'd221, 8'd148, 8'd154, 8'd122, 8'd12,  8'd84,
        8'd82,  8'd163, 8'd44,  8'd139, 8'd228, 8'd236, 8'd205, 8'd242,
        8'd217, 8'd11,  8'd187, 8'd146, 8'd159, 8'd64,  8'd86,  8'd239,
        8'd195, 8'd42,  8'd106, 8'd198, 8'd118, 8'd112, 8'd184, 8'd172,
        8'd87,  8'd2,   8'd173, 8'd117, 8'd176, 8'd229, 8'd247, 8'd253,
        8'd137, 8'd185, 8'd99,  8'd164, 8'd102, 8'd147, 8'd45,  8'd66,
        8'd231, 8'd52,  8'd141, 8'd211, 8'd194, 8'd206, 8'd246, 8'd238,
        8'd56,  8'd110, 8'd78,  8'd248, 8'd63,  8'd240, 8'd189, 8'd93,
        8'd92,  8'd51,  8'd53,  8'd183, 8'd19,  8'd171, 8'd72,  8'd50,
        8'd33,  8'd104, 8'd101, 8'd69,  8'd8,   8'd252, 8'd83,  8'd120,
        8'd76,  8'd135, 8'd85,  8'd54,  8'd202, 8'd125, 8'd188, 8'd213,
        8'd96,  8'd235, 8'd136, 8'd208, 8'd162, 8'd129, 8'd190, 8'd132,
        8'd156, 8'd38,  8'd47,  8'd1,   8'd7,   8'd254, 8'd24,  8'd4,
        8'd216, 8'd131, 8'd89,  8'd21,  8'd28,  8'd133, 8'd37,  8'd153,
        8'd149, 8'd80,  8'd170, 8'd68,  8'd6,   8'd169, 8'd234, 8'd151
    };

    typedef enum logic [1:0] {
        StFirst,
        StAbsorb,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       lane_q [HASH_BYTES];
    logic [7:0]       lane_d [HASH_BYTES];
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       seed_val;
    logic             accept;

`ifdef PEARSON_SEED_EN
    assign seed_val = seed;
`else
    assign seed_val = 8'h00;
`endif

    assign accept = in_valid && in_ready;

    // Handshake outputs are a pure function of the state, so in_ready and out_valid
    // can never be high together.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StFirst:  in_ready  = 1'b1;
            StAbsorb: in_ready  = 1'b1;
            StDone:   out_valid = 1'b1;
            default:  in_ready  = 1'b0;
        endcase
    end

    // Next-state, lane and length update.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        len_d   = len_q;
        unique case (state_q)
            StFirst: begin
                if (accept) begin
                    // Lane j is decorrelated from lane 0 by offsetting the first byte by j.
                    for (int j = 0; j < HASH_BYTES; j++) begin
                        lane_d[j] = PearsonTable[8'(in_data + 8'(j)) ^ seed_val];
                    end
                    len_d   = LEN_W'(1);
                    state_d = in_last ? StDone : StAbsorb;
                end
            end
            StAbsorb: begin
                if (accept) begin
                    for (int j = 0; j < HASH_BYTES; j++) begin
                        lane_d[j] = PearsonTable[lane_q[j] ^ in_data];
                    end
                    // Length saturates; the hash keeps absorbing regardless.
                    if (len_q != {LEN_W{1'b1}}) begin
                        len_d = len_q + LEN_W'(1);
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StFirst;
                end
            end
            default: state_d = StFirst;
        endcase
    end

    // State, lane and length registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFirst;
            len_q   <= '0;
            for (int j = 0; j < HASH_BYTES; j++) begin
                lane_q[j] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            for (int j = 0; j < HASH_BYTES; j++) begin
                lane_q[j] <= lane_d[j];
            end
        end
    end

    // Concatenate lanes with lane 0 in the least-significant byte.
    always_comb begin
        out_hash = '0;
        for (int j = 0; j < HASH_BYTES; j++) begin
            out_hash[8*j +: 8] = lane_q[j];
        end
        out_len = len_q;
    end

endmodule

// File: tb/tb_pearson_stream.sv
// Scoreboard bench for pearson_stream (3 lanes, 3-bit length so saturation is reachable).
// Define PEARSON_SEED_EN to exercise the seeded build.
module tb_pearson_stream;

    localparam int HB     = 3;
    localparam int LW     = 3;
    localparam int MaxLen = (1 << LW) - 1;

    localparam logic [7:0] Tbl [256] = '{
        8'd251, 8'd175, 8'd119, 8'd215, 8'd81,  8'd14,  8'd79,  8'd191,
        8'd103, 8'd49,  8'd181, 8'd143, 8'd186, 8'd157, 8'd0,   8'd232,
        8'd31,  8'd32,  8'd55,  8'd60,  8'd152, 8'd58,  8'd17,  8'd237,
        8'd174, 8'd70,  8'd160, 8'd144, 8'd220, 8'd90,  8'd57,  8'd223,
        8'd59,  8'd3,   8'd18,  8'd140, 8'd111, 8'd166, 8'd203, 8'd196,
        8'd134, 8'd243, 8'd124, 8'd95,  8'd222, 8'd179, 8'd197, 8'd65,
        8'd180, 8'd48,  8'd36,  8'd15,  8'd107, 8'd46,  8'd233, 8'd130,
        8'd165, 8'd30,  8'd123, 8'd161, 8'd209, 8'd23,  8'd97,  8'd16,
        8'd40,  8'd91,  8'd219, 8'd61,  8'd100, 8'd10,  8'd210, 8'd109,
        8'd250, 8'd127, 8'd22,  8'd138, 8'd29,  8'd108, 8'd244, 8'd67,
        8'd207, 8'd9,   8'd178, 8'd204, 8'd74,  8'd98,  8'd126, 8'd249,
        8'd167, 8'd116, 8'd34,  8'd77,  8'd193, 8'd200, 8'd121, 8'd5,
        8'd20,  8'd113, 8'd71,  8'd35,  8'd128, 8'd13,  8'd182, 8'd94,
        8'd25,  8'd226, 8'd227, 8'd199, 8'd75,  8'd27,  8'd41,  8'd245,
        8'd230, 8'd224, 8'd43,  8'd225, 8'd177, 8'd26,  8'd155, 8'd150,
        8'd212, 8'd142, 8'd218, 8'd115, 8'd241, 8'd73,  8'd88,  8'd105,
        8'd39,  8'd114, 8'd62,  8'd255, 8'd192, 8'd201, 8'd145, 8'd214,
        8'd168, 8'd158, 8'd221, 8'd148, 8'd154, 8'd122, 8'd12,  8'd84,
        8'd82,  8'd163, 8'd44,  8'd139, 8'd228, 8'd236, 8'd205, 8'd242,
        8'd217, 8'd11,  8'd187, 8'd146, 8'd159, 8'd64,  8'd86,  8'd239,
        8'd195, 8'd42,  8'd106, 8'd198, 8'd118, 8'd112, 8'd184, 8'd172,
        8'd87,  8'd2,   8'd173, 8'd117, 8'd176, 8'd229, 8'd247, 8'd253,
        8'd137, 8'd185, 8'd99,  8'd164, 8'd102, 8'd147, 8'd45,  8'd66,
        8'd231, 8'd52,  8'd141, 8'd211, 8'd194, 8'd206, 8'd246, 8'd238,
        8'd56,  8'd110, 8'd78,  8'd248, 8'd63,  8'd240, 8'd189, 8'd93,
        8'd92,  8'd51,  8'd53,  8'd183, 8'd19,  8'd171, 8'd72,  8'd50,
        8'd33,  8'd104, 8'd101, 8'd69,  8'd8,   8'd252, 8'd83,  8'd120,
        8'd76,  8'd135, 8'd85,  8'd54,  8'd202, 8'd125, 8'd188, 8'd213,
        8'd96,  8'd235, 8'd136, 8'd208, 8'd162, 8'd129, 8'd190, 8'd132,
        8'd156, 8'd38,  8'd47,  8'd1,   8'd7,   8'd254, 8'd24,  8'd4,
        8'd216, 8'd131, 8'd89,  8'd21,  8'd28,  8'd133, 8'd37,  8'd153,
        8'd149, 8'd80,  8'd170, 8'd68,  8'd6,   8'd169, 8'd234, 8'd151
    };

    typedef struct packed {
        logic [8*HB-1:0] hash;
        logic [LW-1:0]   len;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_data = 8'h00;
    logic            in_last = 1'b0;
    logic [7:0]      seed = 8'h00;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [8*HB-1:0] out_hash;
    logic [LW-1:0]   out_len;

    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 0;  // 0: always ready, 1: random, 2: held low
    logic [7:0] kq [$];

    pearson_stream #(
        .HASH_BYTES (HB),
        .LEN_W      (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef PEARSON_SEED_EN
        .seed      (seed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    // Reference: every lane walks the whole key through the table.
    function automatic logic [8*HB-1:0] model_hash(input logic [7:0] key [$], input logic [7:0] s);
        logic [8*HB-1:0] r;
        logic [7:0]      h;
        r = '0;
        for (int j = 0; j < HB; j++) begin
            h = Tbl[8'(key[0] + j) ^ s];
            for (int i = 1; i < key.size(); i++) h = Tbl[h ^ key[i]];
            r[8*j +: 8] = h;
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] model_len(input int n);
        return LW'((n > MaxLen) ? MaxLen : n);
    endfunction

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each result handshake.
    logic            prev_last_acc = 1'b0;
    logic            prev_hold = 1'b0;
    logic            chk_reset = 1'b0;
    logic [8*HB-1:0] prev_hash = '0;
    logic [LW-1:0]   prev_len = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_last_acc = 1'b0;
            prev_hold     = 1'b0;
            chk_reset     = 1'b1;
        end else begin
            if (chk_reset) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_hash !== '0 || out_len !== '0) begin
                    errors++;
                    $display("FAIL reset_state: valid=%b ready=%b hash=%h len=%0d, need 0 1 0 0",
                             out_valid, in_ready, out_hash, out_len);
                end
                chk_reset = 1'b0;
            end
            checks++;
            if (in_ready !== !out_valid) begin
                errors++;
                $display("FAIL ready_vs_valid: in_ready=%b out_valid=%b", in_ready, out_valid);
            end
            checks++;
            if (out_valid !== (prev_last_acc || prev_hold)) begin
                errors++;
                $display("FAIL out_valid_timing: got %b, need %b", out_valid,
                         prev_last_acc || prev_hold);
            end
            if (prev_hold) begin
                checks++;
                if (out_hash !== prev_hash || out_len !== prev_len) begin
                    errors++;
                    $display("FAIL hold_stable: hash=%h len=%0d, need hash=%h len=%0d",
                             out_hash, out_len, prev_hash, prev_len);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: hash=%h len=%0d, none expected",
                             out_hash, out_len);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_hash !== e.hash || out_len !== e.len) begin
                        errors++;
                        $display("FAIL result: hash=%h len=%0d, need hash=%h len=%0d",
                                 out_hash, out_len, e.hash, e.len);
                    end
                end
            end
            prev_last_acc = in_valid && in_ready && in_last;
            prev_hold     = out_valid && !out_ready;
            prev_hash     = out_hash;
            prev_len      = out_len;
        end
    end

    // Stream a key; abort_after>0 pulses reset after that many bytes are accepted.
    task automatic send_key(input logic [7:0] key [$], input logic [7:0] seed_first,
                            input int gap_max, input int abort_after,
                            input bit use_const, input logic [8*HB-1:0] const_hash);
        exp_t       e;
        logic [7:0] s_used;
        int         budget;
        s_used = 8'h00;
`ifdef PEARSON_SEED_EN
        s_used = seed_first;
`endif
        for (int i = 0; i < key.size(); i++) begin
            int gap;
            gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = key[i];
            in_last  = (i == key.size() - 1);
            seed     = (i == 0) ? seed_first : 8'($urandom);
            budget   = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                budget++;
                if (budget > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: byte %0d not accepted in 50 cycles", i);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (i == key.size() - 1) begin
                e.hash = use_const ? const_hash : model_hash(key, s_used);
                e.len  = model_len(key.size());
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (abort_after == i + 1) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte 0x00: lanes T[0],T[1],T[2]
        kq.delete(); kq.push_back(8'h00);
        send_key(kq, 8'h00, 0, 0, 1'b1, 24'h77AFFB);
        // Two zero bytes back to back: lane0 = T[251] = 0x44
        kq.delete(); kq.push_back(8'h00); kq.push_back(8'h00);
        send_key(kq, 8'h00, 0, 0, 1'b1, 24'h96FD44);
        // 0xFF: lane1 offset wraps to 0x00
        kq.delete(); kq.push_back(8'hFF);
        send_key(kq, 8'h00, 0, 0, 1'b1, 24'hAFFB97);
`ifdef PEARSON_SEED_EN
        kq.delete(); kq.push_back(8'h00);
        send_key(kq, 8'h0E, 0, 0, 1'b1, 24'hBAE800);
        kq.delete(); kq.push_back(8'h5A); kq.push_back(8'h11); kq.push_back(8'hC3);
        send_key(kq, 8'h3C, 1, 0, 1'b0, '0);
`endif
        // Reset after 3 of 6 bytes, then a fresh key 0x01
        kq.delete();
        for (int i = 0; i < 6; i++) kq.push_back(8'(i * 37 + 5));
        send_key(kq, 8'h00, 0, 3, 1'b0, '0);
        kq.delete(); kq.push_back(8'h01);
        send_key(kq, 8'h00, 0, 0, 1'b1, 24'hD777AF);
        // Length saturation with a 9-byte key
        kq.delete();
        for (int i = 0; i < 9; i++) kq.push_back(8'($urandom));
        send_key(kq, 8'h00, 0, 0, 1'b0, '0);

        // Backpressure: hold the result 5+ cycles while the next key waits on in_valid
        ready_mode = 2;
        kq.delete(); kq.push_back(8'h42); kq.push_back(8'h99);
        send_key(kq, 8'h00, 0, 0, 1'b0, '0);
        fork
            begin
                repeat (6) @(posedge clk);
                ready_mode = 0;
            end
        join_none
        kq.delete(); kq.push_back(8'h7E); kq.push_back(8'h00); kq.push_back(8'hE7);
        send_key(kq, 8'h00, 0, 0, 1'b0, '0);

        // Reset while a result is pending discards it
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 2;
        kq.delete(); kq.push_back(8'hA5);
        send_key(kq, 8'h00, 0, 0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;

        // Random keys, gaps and backpressure
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            kq.delete();
            for (int i = 0; i < $urandom_range(12, 1); i++) kq.push_back(8'($urandom));
            send_key(kq, 8'($urandom), 2, 0, 1'b0, '0);
        end

        ready_mode = 0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
